// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg
// Shared types and constants for the ADC capture gate: FSM state encoding,
// trigger-mode codes and default sample geometry.
package adc_cap_pkg;

  localparam int SAMP_W_DEF = 16;
  localparam int NSAMP_DEF  = 8;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_LVL = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_level_detect.sv
// adc_level_detect
// Signed rising level-crossing detector across one beat of NSAMP samples.
// The last sample of the previous valid beat is kept so that a crossing
// spanning a beat boundary is also seen.
// Ports:
//   clk    - RF ADC clock
//   rstb   - synchronous reset, active low
//   valid  - beat valid; the last sample is registered on every valid beat
//   tdata  - packed samples, sample 0 oldest
//   level  - signed threshold
//   hit    - some s[k-1] < level <= s[k] within this beat (combinational)
module adc_level_detect
  import adc_cap_pkg::*;
#(
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int NSAMP  = NSAMP_DEF
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      valid,
  input  logic [SAMP_W*NSAMP-1:0]   tdata,
  input  logic [SAMP_W-1:0]         level,
  output logic                      hit
);

  logic [SAMP_W-1:0]           prev_q;
  logic [SAMP_W-1:0]           prev_d;
  // chain[0] is the previous beat's last sample, chain[k+1] is sample k
  logic [SAMP_W*(NSAMP+1)-1:0] chain;

  assign chain = {tdata, prev_q};

  // next value of the carried-over last sample
  always_comb begin
    if (valid) begin
      prev_d = tdata[SAMP_W*(NSAMP-1) +: SAMP_W];
    end else begin
      prev_d = prev_q;
    end
  end

  // carried-over sample register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // scan adjacent sample pairs for a signed upward crossing
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NSAMP; k++) begin
      if (($signed(chain[SAMP_W*k +: SAMP_W]) < $signed(level)) &&
          ($signed(chain[SAMP_W*(k+1) +: SAMP_W]) >= $signed(level))) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/adc_capture_gate.sv
// adc_capture_gate
// Per-channel capture gate between an RF ADC AXIS stream and its FIFO.
// Arms on a command, waits for a trigger (immediate, external edge or signed
// level crossing), then forwards exactly cap_beats beats through a single
// output register. The ADC cannot be stalled, so beats that find the output
// register full are dropped and flagged as overflow.
// Ports:
//   rf_clk, rf_rstb             - clock, synchronous active-low reset
//   s_axis_*                    - ADC beat input (tready tied high)
//   m_axis_*                    - gated beat output to FIFO
//   arm, abort                  - single-cycle command pulses
//   trig_mode, ext_trig,
//   trig_level                  - trigger selection and sources
//   cap_beats                   - capture length, sampled on arm
//   busy, done, overflow,
//   beat_count                  - status back to the register block
module adc_capture_gate
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int NSAMP  = NSAMP_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              rf_clk,
  input  logic              rf_rstb,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic              ext_trig,
  input  logic [SAMP_W-1:0] trig_level,
  input  logic [CNT_W-1:0]  cap_beats,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  beat_count
);

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cap_len_q, cap_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              ext_q;
  logic              lvl_hit;
  logic              trig_hit;
  logic              slot_free;
  logic              take;
  logic              load;

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tdata  = mdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign beat_count    = cnt_q;
  assign cnt_inc       = cnt_q + CNT_W'(1);

  adc_level_detect #(
    .SAMP_W (SAMP_W),
    .NSAMP  (NSAMP)
  ) u_level_detect (
    .clk   (rf_clk),
    .rstb  (rf_rstb),
    .valid (s_axis_tvalid),
    .tdata (s_axis_tdata),
    .level (trig_level),
    .hit   (lvl_hit)
  );

  // trigger source select; the reserved mode behaves as immediate
  always_comb begin
    case (trig_mode)
      TRIG_EXT: trig_hit = ext_trig & ~ext_q;
      TRIG_LVL: trig_hit = lvl_hit;
      default:  trig_hit = 1'b1;
    endcase
  end

  // next-state, capture accounting and output register control
  always_comb begin
    state_d   = state_q;
    cap_len_d = cap_len_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    mvalid_d  = mvalid_q;
    mdata_d   = mdata_q;
    take      = 1'b0;
    load      = 1'b0;
    // the output slot can take a beat if empty or drained this very cycle
    slot_free = ~mvalid_q | m_axis_tready;

    case (state_q)
      IDLE, DONE: begin
        if (arm && !abort) begin
          cap_len_d = cap_beats;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          if (cap_beats == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ARMED;
            done_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ARMED: begin
        if (!abort && s_axis_tvalid && trig_hit) begin
          take = 1'b1;
        end else begin
          take = 1'b0;
        end
      end
      CAPTURE: begin
        if (!abort && s_axis_tvalid) begin
          take = 1'b1;
        end else begin
          take = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      done_d = done_d;
    end

    // a captured beat either lands in the output slot or is lost
    if (take) begin
      if (slot_free) begin
        load  = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc == cap_len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end else begin
        ovf_d   = 1'b1;
        state_d = CAPTURE;
      end
    end else begin
      load = 1'b0;
    end

    // tvalid/tdata hold until accepted, regardless of FSM state
    if (load) begin
      mvalid_d = 1'b1;
      mdata_d  = s_axis_tdata;
    end else if (m_axis_tready) begin
      mvalid_d = 1'b0;
    end else begin
      mvalid_d = mvalid_q;
    end

    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
  end

  // state and status registers
  always_ff @(posedge rf_clk) begin
    if (!rf_rstb) begin
      state_q   <= IDLE;
      cap_len_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      mvalid_q  <= 1'b0;
      mdata_q   <= '0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_len_q <= cap_len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      mvalid_q  <= mvalid_d;
      mdata_q   <= mdata_d;
      ext_q     <= ext_trig;
    end
  end

endmodule

// File: tb/tb_adc_capture_gate.sv
module tb_adc_capture_gate;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int NS = 8;
  localparam int CW = 32;

  logic          rf_clk = 1'b0;
  logic          rf_rstb;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          arm;
  logic          abort;
  logic [1:0]    trig_mode;
  logic          ext_trig;
  logic [SW-1:0] trig_level;
  logic [CW-1:0] cap_beats;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [CW-1:0] beat_count;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] hs_q[$];

  // reference model state
  bit            mdl_wait, mdl_take, mdl_done, mdl_ovf, mdl_ov, mdl_ext_prev;
  int unsigned   mdl_len, mdl_cnt;
  logic [DW-1:0] mdl_od;
  logic [SW-1:0] mdl_prev;

  adc_capture_gate dut (
    .rf_clk        (rf_clk),
    .rf_rstb       (rf_rstb),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .arm           (arm),
    .abort         (abort),
    .trig_mode     (trig_mode),
    .ext_trig      (ext_trig),
    .trig_level    (trig_level),
    .cap_beats     (cap_beats),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .beat_count    (beat_count)
  );

  always #5 rf_clk = ~rf_clk;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(logic [SW-1:0] v);
    return {NS{v}};
  endfunction

  function automatic logic [DW-1:0] ramp(int b);
    logic [DW-1:0] r;
    for (int k = 0; k < NS; k++) r[SW*k +: SW] = SW'(16 * (NS * b + k));
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // signed upward crossing anywhere in the beat, including from the carried sample
  function automatic bit level_cross(logic [DW-1:0] d, logic [SW-1:0] prev, logic [SW-1:0] lvl);
    shortint a, b, t;
    t = lvl;
    a = prev;
    for (int k = 0; k < NS; k++) begin
      b = d[SW*k +: SW];
      if (a < t && b >= t) return 1'b1;
      a = b;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit drain, fire, accept;
    if (!rf_rstb) begin
      mdl_wait = 0; mdl_take = 0; mdl_done = 0; mdl_ovf = 0; mdl_ov = 0;
      mdl_ext_prev = 0; mdl_len = 0; mdl_cnt = 0; mdl_od = '0; mdl_prev = '0;
      return;
    end
    drain  = mdl_ov && m_axis_tready;
    accept = 0;
    case (trig_mode)
      2'd1:    fire = ext_trig && !mdl_ext_prev;
      2'd2:    fire = level_cross(s_axis_tdata, mdl_prev, trig_level);
      default: fire = 1'b1;
    endcase
    if (abort) begin
      mdl_wait = 0; mdl_take = 0; mdl_done = 0;
    end else if (arm && !mdl_wait && !mdl_take) begin
      mdl_len = cap_beats; mdl_cnt = 0; mdl_ovf = 0;
      mdl_done = (cap_beats == 0);
      mdl_wait = (cap_beats != 0);
    end else if (s_axis_tvalid && (mdl_take || (mdl_wait && fire))) begin
      mdl_wait = 0;
      mdl_take = 1;
      if (!mdl_ov || drain) begin
        accept = 1;
        mdl_cnt++;
        if (mdl_cnt == mdl_len) begin
          mdl_take = 0;
          mdl_done = 1;
        end
      end else begin
        mdl_ovf = 1;
      end
    end
    if (accept) begin
      mdl_ov = 1; mdl_od = s_axis_tdata;
    end else if (drain) begin
      mdl_ov = 0;
    end
    if (s_axis_tvalid) mdl_prev = s_axis_tdata[DW-1 -: SW];
    mdl_ext_prev = ext_trig;
  endtask

  task automatic cyc();
    if (m_axis_tvalid && m_axis_tready) hs_q.push_back(m_axis_tdata);
    model_step();
    @(posedge rf_clk);
    #1;
    chk("tvalid", m_axis_tvalid, mdl_ov);
    chk("tdata", m_axis_tdata, mdl_od);
    chk("busy", busy, mdl_wait || mdl_take);
    chk("done", done, mdl_done);
    chk("overflow", overflow, mdl_ovf);
    chk("beat_count", beat_count, mdl_cnt);
    chk("s_tready", s_axis_tready, 1'b1);
  endtask

  task automatic beat(logic [DW-1:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    cyc();
  endtask

  task automatic idle(int n);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_arm(logic [CW-1:0] len);
    cap_beats     = len;
    arm           = 1'b1;
    s_axis_tvalid = 1'b0;
    cyc();
    arm = 1'b0;
  endtask

  initial begin
    rf_rstb = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    arm = 1'b0; abort = 1'b0; trig_mode = 2'd0; ext_trig = 1'b0;
    trig_level = '0; cap_beats = '0;
    cyc(); cyc();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", beat_count, '0);
    rf_rstb = 1'b1;

    // immediate trigger, arm coincident with the third beat
    hs_q.delete();
    trig_mode = 2'd0; cap_beats = 32'd4;
    for (int i = 0; i < 10; i++) begin
      arm = (i == 2);
      beat(mk(SW'(16'h0A00 + i)));
    end
    arm = 1'b0;
    idle(3);
    chk("m0_beats", DW'(hs_q.size()), DW'(4));
    chk("m0_first", hs_q[0], mk(16'h0A03));
    chk("m0_last", hs_q[3], mk(16'h0A06));
    chk("m0_count", beat_count, 32'd4);
    chk("m0_done", done, 1'b1);
    chk("m0_ovf", overflow, 1'b0);

    // level crossing on a ramp; the crossing sits at sample 0 of beat 2
    hs_q.delete();
    trig_mode = 2'd2; trig_level = 16'h0100; cap_beats = 32'd2;
    arm = 1'b1;
    beat('0);
    arm = 1'b0;
    for (int b = 0; b < 6; b++) beat(ramp(b));
    idle(3);
    chk("m2_beats", DW'(hs_q.size()), DW'(2));
    chk("m2_first", hs_q[0], ramp(2));
    chk("m2_second", hs_q[1], ramp(3));

    // external edge trigger, then no re-trigger while held high
    hs_q.delete();
    trig_mode = 2'd1; ext_trig = 1'b0;
    do_arm(32'd3);
    for (int i = 0; i < 12; i++) begin
      ext_trig = (i >= 7);
      beat(mk(SW'(16'h0B00 + i)));
    end
    idle(3);
    chk("m1_beats", DW'(hs_q.size()), DW'(3));
    chk("m1_first", hs_q[0], mk(16'h0B07));
    chk("m1_last", hs_q[2], mk(16'h0B09));
    hs_q.delete();
    do_arm(32'd3);
    for (int i = 0; i < 5; i++) beat(mk(SW'(16'h0C00 + i)));
    chk("m1_held_busy", busy, 1'b1);
    chk("m1_no_retrig", DW'(hs_q.size()), DW'(0));
    ext_trig = 1'b0;
    beat(mk(16'h0C10));
    ext_trig = 1'b1;
    for (int i = 0; i < 4; i++) beat(mk(SW'(16'h0C20 + i)));
    idle(3);
    chk("m1_retrig_beats", DW'(hs_q.size()), DW'(3));
    chk("m1_retrig_first", hs_q[0], mk(16'h0C20));

    // back-pressure during capture
    hs_q.delete();
    trig_mode = 2'd0; ext_trig = 1'b0; m_axis_tready = 1'b1;
    do_arm(32'd8);
    for (int i = 0; i < 20; i++) begin
      m_axis_tready = !(i >= 3 && i <= 5);
      beat(mk(SW'(16'h0D00 + i)));
    end
    m_axis_tready = 1'b1;
    idle(3);
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_count", beat_count, 32'd8);
    chk("bp_beats", DW'(hs_q.size()), DW'(8));
    chk("bp_done", done, 1'b1);

    // zero-length capture
    hs_q.delete();
    do_arm(32'd0);
    chk("z_done", done, 1'b1);
    chk("z_busy", busy, 1'b0);
    chk("z_tvalid", m_axis_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) beat(mk(SW'(16'h0E00 + i)));
    chk("z_beats", DW'(hs_q.size()), DW'(0));

    // abort with a beat held in the output register
    hs_q.delete();
    do_arm(32'd10);
    for (int i = 0; i < 3; i++) beat(mk(SW'(16'h0F00 + i)));
    m_axis_tready = 1'b0; abort = 1'b1;
    beat(mk(16'h0F03));
    abort = 1'b0;
    beat(mk(16'h0F04));
    beat(mk(16'h0F05));
    chk("ab_held", m_axis_tvalid, 1'b1);
    chk("ab_held_data", m_axis_tdata, mk(16'h0F02));
    m_axis_tready = 1'b1;
    for (int i = 6; i < 10; i++) beat(mk(SW'(16'h0F00 + i)));
    idle(2);
    chk("ab_count", beat_count, 32'd3);
    chk("ab_done", done, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_beats", DW'(hs_q.size()), DW'(3));
    rf_rstb = 1'b0;
    cyc();
    rf_rstb = 1'b1;
    chk("rst2_tvalid", m_axis_tvalid, 1'b0);
    chk("rst2_tdata", m_axis_tdata, '0);
    chk("rst2_count", beat_count, '0);
    chk("rst2_ovf", overflow, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rf_rstb       = ($urandom_range(0, 499) != 0);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = rnd();
      m_axis_tready = ($urandom_range(0, 2) != 0);
      arm           = ($urandom_range(0, 15) == 0);
      abort         = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) ext_trig = ~ext_trig;
      if ($urandom_range(0, 31) == 0) trig_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) trig_level = SW'($urandom_range(0, 65535));
      cap_beats = CW'($urandom_range(0, 6));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
